// File: rtl/fpaa_prog_pkg.sv
// Shared definitions for the FPAA island programming and readback blocks.
//   rb_state_e     : readback controller states
//   DefaultWordW   : default bits per switch-matrix location
//   DefaultSettle  : default select-to-shift settle cycles
//   addr_next_col / addr_next_row / addr_at_end : column-first address advance
package fpaa_prog_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StShift,
        StHold,
        StDrain
    } rb_state_e;

    localparam int unsigned DefaultWordW  = 8;
    localparam int unsigned DefaultSettle = 3;

    // Column-first walk: the column wraps to 0 and the row steps when the last column is passed.
    function automatic int unsigned addr_next_col(input int unsigned col, input int unsigned cols);
        return (col >= cols - 32'd1) ? 32'd0 : col + 32'd1;
    endfunction

    function automatic int unsigned addr_next_row(input int unsigned row, input int unsigned col,
                                                  input int unsigned cols);
        return (col >= cols - 32'd1) ? row + 32'd1 : row;
    endfunction

    // True when the location is the last one of the island, so advancing would leave the matrix.
    function automatic logic addr_at_end(input int unsigned row, input int unsigned col,
                                         input int unsigned rows, input int unsigned cols);
        return (row >= rows - 32'd1) && (col >= cols - 32'd1);
    endfunction

endpackage

// File: rtl/scan_deser.sv
// Serial-to-parallel deserializer for the island scan-out path.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   shift_en    : shift one bit in this cycle (di sampled at the closing edge)
//   di          : serial data, MSB first
//   word_full   : this shift cycle delivers the last bit of a word
//   word        : registered word (complete after a word_full edge)
//   word_next   : word including the bit being shifted in this cycle
module scan_deser #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              di,
    output logic              word_full,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] word_next
);

    localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] shreg_q;
    logic [BW-1:0]     cnt_q;

    assign word_next = {shreg_q[WORD_W-2:0], di};
    assign word_full = shift_en && (cnt_q == BW'(WORD_W - 1));
    assign word      = shreg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shreg_q <= word_next;
            // Counter wraps at the word boundary so the next location starts clean.
            cnt_q   <= word_full ? '0 : cnt_q + BW'(1);
        end
    end

endmodule

// File: rtl/prog_readback_ctrl.sv
// Configuration readback controller for one FPAA island.
// Walks switch-matrix locations column-first, selects each, deserializes its scan-out and
// delivers address-tagged words on a valid/ready stream with one word of output buffering.
//   start/start_row/start_col/word_count : readback request (ignored while busy)
//   busy, done, range_err                : operation status
//   scan_row/scan_col/scan_sel/scan_shift/scan_di : array readback path
//   rd_data/rd_row/rd_col/rd_valid/rd_ready       : output word stream
module prog_readback_ctrl
    import fpaa_prog_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 16,
    parameter int unsigned WORD_W = DefaultWordW,
    parameter int unsigned SETTLE = DefaultSettle,
    parameter int unsigned RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RW-1:0]     start_row,
    input  logic [CW-1:0]     start_col,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [RW-1:0]     scan_row,
    output logic [CW-1:0]     scan_col,
    output logic              scan_sel,
    output logic              scan_shift,
    input  logic              scan_di,
    output logic [WORD_W-1:0] rd_data,
    output logic [RW-1:0]     rd_row,
    output logic [CW-1:0]     rd_col,
    output logic              rd_valid,
    input  logic              rd_ready
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    rb_state_e         state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [15:0]       count_q, count_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic [RW-1:0]     rd_row_q, rd_row_d;
    logic [CW-1:0]     rd_col_q, rd_col_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              range_err_q, range_err_d;

    logic              sel, shift, xfer, out_free, word_full;
    logic [WORD_W-1:0] word, word_next, xfer_word;

    scan_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift),
        .di        (scan_di),
        .word_full (word_full),
        .word      (word),
        .word_next (word_next)
    );

    // Output register can take a word if empty or being emptied at this edge.
    assign out_free = !rd_valid_q || rd_ready;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        count_d     = count_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_data_d   = rd_data_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        rd_valid_d  = rd_valid_q;
        done_d      = 1'b0;
        range_err_d = range_err_q;
        sel         = 1'b0;
        shift       = 1'b0;
        xfer        = 1'b0;
        xfer_word   = '0;

        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    range_err_d = 1'b0;
                    if (word_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        count_d  = word_count;
                        row_d    = start_row;
                        col_d    = start_col;
                        settle_d = '0;
                        state_d  = StSettle;
                    end
                end
            end
            StSettle: begin
                sel = 1'b1;
                if (settle_q == SW'(SETTLE - 1)) state_d = StShift;
                else                             settle_d = settle_q + SW'(1);
            end
            StShift: begin
                sel   = 1'b1;
                shift = 1'b1;
                if (word_full) begin
                    // Last bit bypasses the shift register so the word lands without a bubble.
                    if (out_free) begin
                        xfer      = 1'b1;
                        xfer_word = word_next;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                sel = 1'b1;
                if (out_free) begin
                    xfer      = 1'b1;
                    xfer_word = word;
                end
            end
            StDrain: begin
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (xfer) begin
            rd_valid_d = 1'b1;
            rd_data_d  = xfer_word;
            rd_row_d   = row_q;
            rd_col_d   = col_q;
            count_d    = count_q - 16'd1;
            if (count_q == 16'd1) begin
                state_d = StDrain;
            end else if (addr_at_end(32'(row_q), 32'(col_q), ROWS, COLS)) begin
                range_err_d = 1'b1;
                state_d     = StDrain;
            end else begin
                row_d    = RW'(addr_next_row(32'(row_q), 32'(col_q), COLS));
                col_d    = CW'(addr_next_col(32'(col_q), COLS));
                settle_d = '0;
                state_d  = StSettle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            count_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            rd_data_q   <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            count_q     <= count_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_data_q   <= rd_data_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign range_err  = range_err_q;
    assign scan_row   = row_q;
    assign scan_col   = col_q;
    assign scan_sel   = sel;
    assign scan_shift = shift;
    assign rd_data    = rd_data_q;
    assign rd_row     = rd_row_q;
    assign rd_col     = rd_col_q;
    assign rd_valid   = rd_valid_q;

endmodule
